// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ============================================================================
//  Module   : imem_fetch_responder
//  Summary  : Instruction-memory responder with fixed read latency, bounded
//             outstanding requests, flush and a program-load write port.
//             Optional IMEM_STATS_EN adds rsp_count / err_seen outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_responder #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2   // legal range 1..4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic [ADDR_W-1:0]     req_addr,
   output logic                  req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ADDR_W-1:0]     rsp_addr,
   output logic [DATA_W-1:0]     rsp_instr,
   output logic                  rsp_err,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_addr,
   input  logic [DATA_W-1:0]     wr_data
`ifdef IMEM_STATS_EN
   ,
   output logic [15:0]           rsp_count,
   output logic                  err_seen
`endif
);

   localparam int c_CAP   = LATENCY + 1;
   localparam int c_DEPTH = 2 ** DEPTH_LOG2;
   localparam int c_CNT_W = $clog2(c_CAP + 1);
   localparam int c_PTR_W = $clog2(c_CAP);
   localparam logic [c_CNT_W-1:0] c_CAP_N    = c_CNT_W'(c_CAP);
   localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(c_CAP - 1);

   logic [DATA_W-1:0]     r_mem [c_DEPTH];
   logic                  r_ready_en;
   logic [c_CNT_W-1:0]    r_outstanding;

   logic                  r_pv [LATENCY];
   logic [ADDR_W-1:0]     r_pa [LATENCY];
   logic [DATA_W-1:0]     r_pi [LATENCY];
   logic                  r_pe [LATENCY];

   logic [ADDR_W-1:0]     r_qa [c_CAP];
   logic [DATA_W-1:0]     r_qi [c_CAP];
   logic                  r_qe [c_CAP];
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_CNT_W-1:0]    r_q_cnt;

   logic                  w_oor;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic [DATA_W-1:0]     w_rd_instr;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;

   // Any address bit above the array index marks the fetch as out of range.
   generate
      if (ADDR_W > DEPTH_LOG2) begin : g_oor
         assign w_oor = |req_addr[ADDR_W-1:DEPTH_LOG2];
      end else begin : g_no_oor
         assign w_oor = 1'b0;
      end
   endgenerate

   assign w_idx      = req_addr[DEPTH_LOG2-1:0];
   assign w_rd_instr = w_oor ? '0 : r_mem[w_idx];

   assign req_ready = r_ready_en && (r_outstanding < c_CAP_N) && !flush;
   assign w_accept  = req_valid && req_ready;
   assign rsp_valid = (r_q_cnt != '0);
   assign w_pop     = rsp_valid && rsp_ready && !flush;
   assign w_push    = r_pv[LATENCY-1] && !flush;

   assign rsp_addr  = r_qa[r_rd_ptr];
   assign rsp_instr = r_qi[r_rd_ptr];
   assign rsp_err   = r_qe[r_rd_ptr];

   // Array holds no reset; the read above sees pre-write data on a same-edge write.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ready_en    <= 1'b0;
         r_outstanding <= '0;
      end else begin
         r_ready_en <= 1'b1;
         if (flush) begin
            r_outstanding <= '0;
         end else begin
            r_outstanding <= r_outstanding + c_CNT_W'(w_accept) - c_CNT_W'(w_pop);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_pv[i] <= 1'b0;
            r_pa[i] <= '0;
            r_pi[i] <= '0;
            r_pe[i] <= 1'b0;
         end
      end else begin
         r_pv[0] <= w_accept && !flush;
         r_pa[0] <= req_addr;
         r_pi[0] <= w_rd_instr;
         r_pe[0] <= w_oor;
         for (int i = 1; i < LATENCY; i++) begin
            r_pv[i] <= r_pv[i-1] && !flush;
            r_pa[i] <= r_pa[i-1];
            r_pi[i] <= r_pi[i-1];
            r_pe[i] <= r_pe[i-1];
         end
      end
   end

   // Output queue: circular buffer of CAP entries; cannot overflow since
   // queued plus in-pipe entries never exceed the outstanding limit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < c_CAP; i++) begin
            r_qa[i] <= '0;
            r_qi[i] <= '0;
            r_qe[i] <= 1'b0;
         end
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_q_cnt  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_q_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_qa[r_wr_ptr] <= r_pa[LATENCY-1];
            r_qi[r_wr_ptr] <= r_pi[LATENCY-1];
            r_qe[r_wr_ptr] <= r_pe[LATENCY-1];
            r_wr_ptr       <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
         end
         r_q_cnt <= r_q_cnt + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
   end

`ifdef IMEM_STATS_EN
   logic [15:0] r_rsp_count;
   logic        r_err_seen;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rsp_count <= '0;
         r_err_seen  <= 1'b0;
      end else if (w_pop) begin
         r_rsp_count <= r_rsp_count + 16'd1;
         r_err_seen  <= r_err_seen | rsp_err;
      end
   end

   assign rsp_count = r_rsp_count;
   assign err_seen  = r_err_seen;
`endif

endmodule
`default_nettype wire
